// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared types, header field positions and frame-length table for the MP3 frame sequencer
package mp3_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HDR,
    ST_CRC,
    ST_SIDE,
    ST_MAIN
  } state_t;

  localparam int SIDE_LEN_MONO   = 17;
  localparam int SIDE_LEN_STEREO = 32;

  localparam int HDR_PROT_BIT = 16;
  localparam int HDR_BR_MSB   = 15;
  localparam int HDR_BR_LSB   = 12;
  localparam int HDR_SF_MSB   = 11;
  localparam int HDR_SF_LSB   = 10;
  localparam int HDR_PAD_BIT  = 9;
  localparam int HDR_MODE_MSB = 7;
  localparam int HDR_MODE_LSB = 6;

  // floor(144 * kbps * 1000 / fs); rows are 44.1k, 48k, 32k, columns the bitrate index
  localparam logic [10:0] FRAME_LEN_ROM [3][16] = '{
    '{11'd0, 11'd104, 11'd130, 11'd156, 11'd182, 11'd208, 11'd261, 11'd313,
      11'd365, 11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044, 11'd0},
    '{11'd0, 11'd96, 11'd120, 11'd144, 11'd168, 11'd192, 11'd240, 11'd288,
      11'd336, 11'd384, 11'd480, 11'd576, 11'd672, 11'd768, 11'd960, 11'd0},
    '{11'd0, 11'd144, 11'd180, 11'd216, 11'd252, 11'd288, 11'd360, 11'd432,
      11'd504, 11'd576, 11'd720, 11'd864, 11'd1008, 11'd1152, 11'd1440, 11'd0}
  };

  // Second sync byte: 111 sync tail, MPEG-1, Layer III; bit 0 is the protection bit
  function automatic logic is_sync_byte(input logic [7:0] b);
    return b[7:1] == 7'b1111101;
  endfunction

endpackage

// File: rtl/mp3_hdr_check.sv
// rtl/mp3_hdr_check.sv - combinational MPEG-1 Layer III header validation and frame length lookup
module mp3_hdr_check (
  input  logic [31:0] i_hdr,
  output logic        o_ok,
  output logic        o_mono,
  output logic        o_crc,
  output logic [10:0] o_frame_len
);
  import mp3_pkg::*;

  logic [3:0]  w_br;
  logic [1:0]  w_sf;
  logic [10:0] w_base;
  logic [5:0]  w_min_len;
  logic        w_unused;

  assign w_br     = i_hdr[HDR_BR_MSB:HDR_BR_LSB];
  assign w_sf     = i_hdr[HDR_SF_MSB:HDR_SF_LSB];
  assign o_mono   = (i_hdr[HDR_MODE_MSB:HDR_MODE_LSB] == 2'b11);
  assign o_crc    = ~i_hdr[HDR_PROT_BIT];
  assign w_unused = ^{i_hdr[31:17], i_hdr[8], i_hdr[5:0]};

  always_comb begin
    w_base = '0;
    case (w_sf)
      2'd0:    w_base = FRAME_LEN_ROM[0][w_br];
      2'd1:    w_base = FRAME_LEN_ROM[1][w_br];
      2'd2:    w_base = FRAME_LEN_ROM[2][w_br];
      default: w_base = '0;
    endcase
  end

  assign o_frame_len = w_base + {10'd0, i_hdr[HDR_PAD_BIT]};

  // A frame must hold the header, optional CRC and all side info plus at least one main byte
  assign w_min_len = 6'd4 + (o_crc ? 6'd2 : 6'd0)
                   + (o_mono ? 6'(SIDE_LEN_MONO) : 6'(SIDE_LEN_STEREO));

  assign o_ok = (w_br != 4'd0) && (w_br != 4'hF) && (w_sf != 2'd3)
             && (o_frame_len > {5'd0, w_min_len});

endmodule

// File: rtl/mp3_frame_sequencer.sv
// rtl/mp3_frame_sequencer.sv - MP3 sync hunt, header capture and side/main byte sequencing
// FRAME_STATS_EN adds saturating frames_ok / sync_errs counters.
module mp3_frame_sequencer #(
  parameter int FRAME_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             axiid,
  input  logic                   axiiv,
  output logic [FRAME_CNT_W-1:0] frame_byte_cnt,
  output logic [31:0]            hdr,
  output logic                   hdr_valid,
  output logic                   mono,
  output logic [7:0]             side_byte,
  output logic                   side_valid,
  output logic [4:0]             side_idx,
  output logic                   side_done,
  output logic [7:0]             main_byte,
  output logic                   main_valid,
  output logic                   frame_done,
  output logic                   sync_err
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]            frames_ok,
  output logic [15:0]            sync_errs
`endif
);
  import mp3_pkg::*;

  state_t                 r_state;
  logic                   r_got_ff;
  logic                   r_hdr_phase;
  logic [7:0]             r_b1;
  logic [7:0]             r_b2;
  logic [4:0]             r_sub;
  logic [4:0]             r_side_last;
  logic [FRAME_CNT_W-1:0] r_last_cnt;
  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [31:0]            r_hdr;
  logic                   r_hdr_valid;
  logic [7:0]             r_side_byte;
  logic                   r_side_valid;
  logic [4:0]             r_side_idx;
  logic                   r_side_done;
  logic [7:0]             r_main_byte;
  logic                   r_main_valid;
  logic                   r_frame_done;
  logic                   r_sync_err;

  logic [31:0]            w_cand_hdr;
  logic                   w_ok;
  logic                   w_mono;
  logic                   w_crc;
  logic [10:0]            w_len;
  logic [FRAME_CNT_W-1:0] w_cnt_next;

  assign w_cand_hdr = {8'hFF, r_b1, r_b2, axiid};
  assign w_cnt_next = r_cnt + FRAME_CNT_W'(1);

  mp3_hdr_check u_hdr_check (
    .i_hdr       (w_cand_hdr),
    .o_ok        (w_ok),
    .o_mono      (w_mono),
    .o_crc       (w_crc),
    .o_frame_len (w_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HUNT;
      r_got_ff     <= 1'b0;
      r_hdr_phase  <= 1'b0;
      r_b1         <= '0;
      r_b2         <= '0;
      r_sub        <= '0;
      r_side_last  <= '0;
      r_last_cnt   <= '0;
      r_cnt        <= '0;
      r_hdr        <= '0;
      r_hdr_valid  <= 1'b0;
      r_side_byte  <= '0;
      r_side_valid <= 1'b0;
      r_side_idx   <= '0;
      r_side_done  <= 1'b0;
      r_main_byte  <= '0;
      r_main_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_hdr_valid  <= 1'b0;
      r_side_valid <= 1'b0;
      r_side_done  <= 1'b0;
      r_main_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (axiiv) begin
        case (r_state)
          ST_HUNT: begin
            // A repeated 0xFF simply becomes the new candidate for byte 0
            if (r_got_ff && is_sync_byte(axiid)) begin
              r_b1        <= axiid;
              r_cnt       <= FRAME_CNT_W'(1);
              r_got_ff    <= 1'b0;
              r_hdr_phase <= 1'b0;
              r_state     <= ST_HDR;
            end else if (axiid == 8'hFF) begin
              r_got_ff <= 1'b1;
              r_cnt    <= '0;
            end else begin
              r_got_ff <= 1'b0;
            end
          end
          ST_HDR: begin
            r_cnt <= w_cnt_next;
            if (!r_hdr_phase) begin
              r_b2        <= axiid;
              r_hdr_phase <= 1'b1;
            end else if (w_ok) begin
              r_hdr       <= w_cand_hdr;
              r_hdr_valid <= 1'b1;
              r_last_cnt  <= FRAME_CNT_W'(w_len) - FRAME_CNT_W'(1);
              r_side_last <= w_mono ? 5'(SIDE_LEN_MONO - 1) : 5'(SIDE_LEN_STEREO - 1);
              r_sub       <= '0;
              r_state     <= w_crc ? ST_CRC : ST_SIDE;
            end else begin
              r_sync_err <= 1'b1;
              r_state    <= ST_HUNT;
            end
          end
          ST_CRC: begin
            r_cnt <= w_cnt_next;
            if (r_sub == 5'd1) begin
              r_sub   <= '0;
              r_state <= ST_SIDE;
            end else begin
              r_sub <= r_sub + 5'd1;
            end
          end
          ST_SIDE: begin
            r_cnt        <= w_cnt_next;
            r_side_valid <= 1'b1;
            r_side_byte  <= axiid;
            r_side_idx   <= r_sub;
            if (r_sub == r_side_last) begin
              r_side_done <= 1'b1;
              r_state     <= ST_MAIN;
            end else begin
              r_sub <= r_sub + 5'd1;
            end
          end
          ST_MAIN: begin
            r_cnt        <= w_cnt_next;
            r_main_valid <= 1'b1;
            r_main_byte  <= axiid;
            if (w_cnt_next == r_last_cnt) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_HUNT;
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign frame_byte_cnt = r_cnt;
  assign hdr            = r_hdr;
  assign hdr_valid      = r_hdr_valid;
  assign mono           = (r_hdr[HDR_MODE_MSB:HDR_MODE_LSB] == 2'b11);
  assign side_byte      = r_side_byte;
  assign side_valid     = r_side_valid;
  assign side_idx       = r_side_idx;
  assign side_done      = r_side_done;
  assign main_byte      = r_main_byte;
  assign main_valid     = r_main_valid;
  assign frame_done     = r_frame_done;
  assign sync_err       = r_sync_err;

`ifdef FRAME_STATS_EN
  logic [15:0] r_frames_ok;
  logic [15:0] r_sync_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames_ok <= '0;
      r_sync_errs <= '0;
    end else begin
      if (r_frame_done && (r_frames_ok != 16'hFFFF)) r_frames_ok <= r_frames_ok + 16'd1;
      if (r_sync_err && (r_sync_errs != 16'hFFFF)) r_sync_errs <= r_sync_errs + 16'd1;
    end
  end

  assign frames_ok = r_frames_ok;
  assign sync_errs = r_sync_errs;
`endif

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// tb/tb_mp3_frame_sequencer.sv - scoreboard bench for mp3_frame_sequencer (optional FRAME_STATS_EN checks)
module tb_mp3_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  axiid = 8'h00;
  logic        axiiv = 1'b0;
  logic [31:0] frame_byte_cnt;
  logic [31:0] hdr;
  logic        hdr_valid;
  logic        mono;
  logic [7:0]  side_byte;
  logic        side_valid;
  logic [4:0]  side_idx;
  logic        side_done;
  logic [7:0]  main_byte;
  logic        main_valid;
  logic        frame_done;
  logic        sync_err;
`ifdef FRAME_STATS_EN
  logic [15:0] frames_ok;
  logic [15:0] sync_errs;
`endif

  always #5 clk = ~clk;

  mp3_frame_sequencer #(.FRAME_CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .axiid          (axiid),
    .axiiv          (axiiv),
    .frame_byte_cnt (frame_byte_cnt),
    .hdr            (hdr),
    .hdr_valid      (hdr_valid),
    .mono           (mono),
    .side_byte      (side_byte),
    .side_valid     (side_valid),
    .side_idx       (side_idx),
    .side_done      (side_done),
    .main_byte      (main_byte),
    .main_valid     (main_valid),
    .frame_done     (frame_done),
    .sync_err       (sync_err)
`ifdef FRAME_STATS_EN
    ,
    .frames_ok      (frames_ok),
    .sync_errs      (sync_errs)
`endif
  );

  localparam int K_HDR  = 1;
  localparam int K_ERR  = 2;
  localparam int K_SIDE = 3;
  localparam int K_MAIN = 4;
  localparam int K_BAD  = 9;

  typedef struct {
    int          kind;
    logic [31:0] hdr;
    logic [7:0]  data;
    int          idx;
    int          cnt;
    bit          last;
    bit          mono;
  } ev_t;

  ev_t         q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_hdr = 32'h0;
  int          m_ok = 0;
  int          m_err = 0;
  int          br_kbps[16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
  int          fs_hz[4]    = '{44100, 48000, 32000, 1};

  function automatic void push(input int kind, input logic [31:0] h, input logic [7:0] d,
                               input int idx, input int cnt, input bit last);
    ev_t e;
    e.kind = kind; e.hdr = h; e.data = d; e.idx = idx; e.cnt = cnt; e.last = last;
    e.mono = (h[7:6] == 2'b11);
    q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t a;
    ev_t e;
    int  nv;
    bit  ok;
    if (hdr_valid | sync_err | side_valid | main_valid | side_done | frame_done) begin
      nv = int'(hdr_valid) + int'(sync_err) + int'(side_valid) + int'(main_valid);
      a.kind = (nv != 1) ? K_BAD : hdr_valid ? K_HDR : sync_err ? K_ERR : side_valid ? K_SIDE : K_MAIN;
      a.hdr  = hdr;
      a.data = side_valid ? side_byte : main_byte;
      a.idx  = int'(side_idx);
      a.cnt  = int'(frame_byte_cnt);
      a.last = side_done | frame_done;
      a.mono = mono;
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got kind=%0d cnt=%0d, required no output", a.kind, a.cnt);
      end else begin
        e  = q.pop_front();
        ok = (a.kind == e.kind) && (a.hdr == e.hdr) && (a.cnt == e.cnt)
          && (a.last == e.last) && (a.mono == e.mono)
          && !(side_valid && frame_done) && !(main_valid && side_done);
        if (e.kind == K_SIDE) ok = ok && (a.data == e.data) && (a.idx == e.idx);
        if (e.kind == K_MAIN) ok = ok && (a.data == e.data);
        if (!ok) begin
          n_bad++;
          $display("FAIL event: got kind=%0d hdr=%h data=%h idx=%0d cnt=%0d last=%0b mono=%0b, required kind=%0d hdr=%h data=%h idx=%0d cnt=%0d last=%0b mono=%0b",
                   a.kind, a.hdr, a.data, a.idx, a.cnt, a.last, a.mono,
                   e.kind, e.hdr, e.data, e.idx, e.cnt, e.last, e.mono);
        end
      end
    end
  end

  task automatic put(input logic [7:0] b, input int gap);
    if (gap == 2 || (gap == 1 && $urandom_range(0, 3) == 0)) begin
      axiiv = 1'b0;
      axiid = 8'($urandom);
      @(posedge clk); #1;
    end
    axiid = b;
    axiiv = 1'b1;
    @(posedge clk); #1;
    axiiv = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic any;
    any = (|hdr) | (|frame_byte_cnt) | hdr_valid | mono | (|side_byte) | side_valid
        | (|side_idx) | side_done | (|main_byte) | main_valid | frame_done | sync_err;
`ifdef FRAME_STATS_EN
    any = any | (|frames_ok) | (|sync_errs);
`endif
    n_vec++;
    if (any) begin
      n_bad++;
      $display("FAIL %s: outputs not all zero (hdr=%h cnt=%0d side_v=%0b main_v=%0b), required all zero",
               name, hdr, frame_byte_cnt, side_valid, main_valid);
    end
  endtask

  task automatic do_reset(input string name);
    rst   = 1'b1;
    axiiv = 1'b1;
    axiid = 8'hFF;
    @(posedge clk); #1;
    check_zero(name);
    @(posedge clk); #1;
    rst   = 1'b0;
    axiiv = 1'b0;
    m_hdr = 32'h0;
    m_ok  = 0;
    m_err = 0;
  endtask

  // Expected events come from the frame layout: header, optional CRC, side info, main data
  task automatic send_frame(input logic [31:0] h, input int gap, input int abort_at);
    int         br, sf, len, crc, side, limit;
    logic [7:0] bytes[$];
    br = int'(h[15:12]);
    sf = int'(h[11:10]);
    if (br == 0 || br == 15 || sf == 3) begin
      push(K_ERR, m_hdr, 8'h00, 0, 3, 1'b0);
      m_err++;
      for (int i = 0; i < 4; i++) put(h[31 - 8 * i -: 8], gap);
      return;
    end
    len   = (144 * br_kbps[br] * 1000) / fs_hz[sf] + int'(h[9]);
    crc   = h[16] ? 0 : 2;
    side  = (h[7:6] == 2'b11) ? 17 : 32;
    limit = (abort_at >= 0) ? abort_at : len;
    for (int i = 0; i < len; i++) bytes.push_back(i < 4 ? h[31 - 8 * i -: 8] : 8'($urandom));
    for (int i = 0; i < limit; i++) begin
      if (i == 3) begin
        m_hdr = h;
        push(K_HDR, h, 8'h00, 0, 3, 1'b0);
      end else if (i >= 4 + crc && i < 4 + crc + side) begin
        push(K_SIDE, h, bytes[i], i - 4 - crc, i, i == 4 + crc + side - 1);
      end else if (i >= 4 + crc + side) begin
        push(K_MAIN, h, bytes[i], 0, i, i == len - 1);
      end
    end
    if (limit == len) m_ok++;
    for (int i = 0; i < limit; i++) put(bytes[i], gap);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0]  br;
    logic [1:0]  sf;
    logic [8:0]  low;
    logic [31:0] h;
    int          t;
    int          nj;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    send_frame(32'hFFFB90C4, 0, -1);
    send_frame(32'hFFFA9204, 0, -1);
    put(8'h00, 0);
    put(8'hFF, 0);
    send_frame(32'hFFFB90C4, 0, -1);
    send_frame(32'hFFFBF0C4, 0, -1);
    send_frame(32'hFFFB9CC4, 0, -1);
    send_frame(32'hFFFA9204, 0, -1);
    send_frame(32'hFFFB90C4, 2, -1);
    send_frame(32'hFFFB90C4, 0, 100);
    do_reset("mid_frame_reset");
    send_frame(32'hFFFA9204, 1, -1);

    for (int f = 0; f < 10; f++) begin
      nj = $urandom_range(0, 4);
      for (int j = 0; j < nj; j++) put(8'($urandom_range(0, 254)), 1);
      if ($urandom_range(0, 3) == 0) begin
        put(8'hFF, 0);
        case ($urandom_range(0, 2))
          0:       put(8'hFD, 0);
          1:       put(8'hE3, 0);
          default: put(8'h7B, 0);
        endcase
      end
      br  = 4'($urandom_range(1, 14));
      sf  = 2'($urandom_range(0, 2));
      low = 9'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) br = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
        else sf = 2'd3;
      end
      h = {8'hFF, 7'b1111101, 1'($urandom), br, sf, 1'($urandom), low};
      send_frame(h, int'($urandom_range(0, 1)), -1);
    end

    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d outstanding, required 0", q.size());
    end
`ifdef FRAME_STATS_EN
    n_vec++;
    if (int'(frames_ok) != m_ok) begin
      n_bad++;
      $display("FAIL frames_ok: got %0d, required %0d", frames_ok, m_ok);
    end
    n_vec++;
    if (int'(sync_errs) != m_err) begin
      n_bad++;
      $display("FAIL sync_errs: got %0d, required %0d", sync_errs, m_err);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mp3_frame_sequencer.md
# mp3_frame_sequencer

Byte-stream controller that sits between the raw MP3 byte source and the side-information parser. Hunts for MPEG-1 Layer III sync, captures the 4-byte frame header, skips the optional CRC, and sequences each frame into side-info bytes and main-data bytes. It also drives the frame-relative byte counter the side-info parser consumes. The block tracks frame length from the header so it can re-sync at the next frame boundary.

## Interface
- `FRAME_CNT_W`, default 32: width of `frame_byte_cnt`.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `axiid` input 8: input byte.
- `axiiv` input 1: `axiid` valid this cycle. There is no backpressure.
- `frame_byte_cnt` output FRAME_CNT_W: index within the current frame of the byte just forwarded. The first header byte is 0.
- `hdr` output 32: captured frame header, held until the next header completes.
- `hdr_valid` output 1: one-cycle pulse when `hdr` updates.
- `mono` output 1: `hdr` mode == 2'b11.
- `side_byte` output 8: side-info byte.
- `side_valid` output 1: `side_byte` valid.
- `side_idx` output 5: side-info byte index, 0..16 (mono) or 0..31 (stereo).
- `side_done` output 1: pulse with the last side byte.
- `main_byte` output 8: main-data byte.
- `main_valid` output 1: `main_byte` valid.
- `frame_done` output 1: pulse with the last byte of a frame.
- `sync_err` output 1: pulse when a header is rejected.

## Operation
- States are HUNT, HDR, CRC, SIDE, MAIN.
- **HUNT:** wait for byte 0xFF. If the next valid byte b satisfies b[7:5]=3'b111, b[4:3]=2'b11 (MPEG-1) and b[2:1]=2'b01 (Layer III), go to HDR.
  - 0xFF followed by 0xFF: the second 0xFF becomes the new candidate.
  - Any other byte: discard and stay in HUNT.
- **HDR:** capture bytes 2 and 3, then validate.
  - Reject if bitrate_index (hdr[15:12]) is 0 or 15, or if sampling index (hdr[11:10]) is 3. On rejection: pulse `sync_err`, return to HUNT, leave `hdr` unchanged.
  - On acceptance: pulse `hdr_valid`, compute `frame_len`, then go to CRC if protection_bit hdr[16]==0, else to SIDE.
- **frame_len** = FRAME_LEN_ROM[sampling][bitrate] + padding (hdr[9]). The ROM holds floor(144·bitrate·1000/fs) and is 11 bits wide. Example: 128 kbps at 44.1 kHz gives 417.
- **CRC:** swallow 2 bytes. They are not forwarded.
- **SIDE:** forward exactly 17 bytes (mono) or 32 bytes (stereo) on `side_*`. `side_idx` counts from 0. `side_done` fires on the last one.
- **MAIN:** forward bytes on `main_*` until `frame_byte_cnt == frame_len-1`. On that byte, pulse `frame_done` and go to HUNT.
  - The next header is expected immediately, but is re-verified through HUNT.
- `frame_byte_cnt` advances once per valid byte in every state except HUNT. It is driven with the index of each forwarded or swallowed byte.
- If frame_len is not greater than 4 + crc + side length, treat the header as rejected (`sync_err`). This cannot occur with legal ROM contents but must be handled.

## Timing
- All outputs are registered, with one-cycle latency from the `axiiv` byte to the corresponding `*_valid` / `frame_byte_cnt` update.
- `axiiv` low: the state machine holds and all valid/pulse outputs are 0 that cycle.
- `hdr_valid` / `sync_err` assert in the cycle after byte 3 is accepted.
- `side_done` coincides with the final `side_valid`. `frame_done` coincides with the final `main_valid`.
- Reset:
  - All outputs go to 0, `hdr` goes to 0, and state goes to HUNT.
  - A reset mid-frame discards the partial frame with no `frame_done`.
  - Reset dominates a simultaneous `axiiv`.
- The counter never wraps within a legal frame, since the maximum frame_len is 1441.

## Configuration
- `FRAME_STATS_EN` defined adds two outputs, each 16-bit and saturating at 0xFFFF, both reset to 0:
  - `frames_ok`: increments on `frame_done`.
  - `sync_errs`: increments on `sync_err`.
- Without the macro, neither port nor its counter exists.

## Structure
- Package `mp3_pkg`:
  - State enum.
  - `FRAME_LEN_ROM` constant [3][16] of 11 bits.
  - Side-info lengths `SIDE_LEN_MONO`=17 and `SIDE_LEN_STEREO`=32.
  - Header field bit-position constants.
- Optional sub-module `mp3_hdr_check`: combinational header validation plus frame_len lookup.
- The rest is one sequential module.

## Test plan
- **Mono, no CRC:** header FF FB 90 C4 (128 kbps, 44.1 kHz, no pad, mono) then 413 bytes → `hdr_valid` once; `side_valid` for cnt 4..20 with idx 0..16; `main_valid` for cnt 21..416; `frame_done` at cnt 416.
- **Stereo with CRC and padding:** FF FA 92 04 → frame_len 418; bytes 4–5 swallowed; side at cnt 6..37; main 38..417; `frame_done` at 417.
- **Junk and sync:** 00 FF FF FB 90 C4 → sync found on the second FF; `frame_byte_cnt`=0 is reported for that FF's position; first `side_valid` at cnt 4.
- **Bad headers:** bitrate_index=15 (FF FB F0 C4), or sampling=3 → `sync_err` pulse, no `hdr_valid`, back to HUNT; the following valid frame parses normally.
- **Gaps and reset:** `axiiv` toggling every other cycle through a frame gives identical output sequences. `rst` asserted at cnt 100 → all outputs 0, no `frame_done`; the next frame parses from HUNT.
- **Stats (FRAME_STATS_EN):** 3 good frames plus 1 bad header → `frames_ok`=3, `sync_errs`=1.
